// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: program-ROM fetch front end that assembles 1/2-byte instructions into a valid/ready queue
module rom_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_read_o,
    output logic              rom_ena_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_op_o,
    output logic [DATA_W-1:0] instr_arg_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              halted_o,
    output logic              busy_o
);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_ARG, HALTED} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] op;
        logic [DATA_W-1:0] arg;
        logic [ADDR_W-1:0] pc;
    } entry_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, opc_q, opc_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            push_e, head;
    logic              full, rd, two, push, pop;
    logic [2:0]        opc;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    assign full   = cnt_q == CW'(FIFO_DEPTH);
    // fullness is judged on the registered count so a same-cycle pop cannot start a fetch
    assign rd     = (state_q == FETCH_OP && !full) || state_q == FETCH_ARG;
    assign opc    = rom_data_i[DATA_W-1 -: 3];
    assign two    = opc inside {3'b001, 3'b010, 3'b011};
    assign push   = rd && !(state_q == FETCH_OP && two) && !jmp_en_i;
    assign pop    = cnt_q != '0 && instr_ready_i && !jmp_en_i;
    assign push_e = state_q == FETCH_ARG ? {op_q, rom_data_i, opc_q} : {rom_data_i, DATA_W'(0), pc_q};
    always_comb begin
        state_d = state_q;
        pc_d    = rd ? pc_q + ADDR_W'(1) : pc_q;
        op_d    = op_q;
        opc_d   = opc_q;
        if (state_q == IDLE || state_q == HALTED) state_d = start_i ? FETCH_OP : state_q;
        else if (state_q == FETCH_ARG) state_d = FETCH_OP;
        else if (rd) state_d = two ? FETCH_ARG : (opc == 3'b111 ? HALTED : FETCH_OP);
        if (state_q == FETCH_OP && rd) begin
            op_d  = rom_data_i;
            opc_d = pc_q;
        end
        if (jmp_en_i) begin
            state_d = FETCH_OP;
            pc_d    = jmp_addr_i;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(START_ADDR);
            op_q    <= '0;
            opc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            opc_q   <= opc_d;
            rd_q    <= jmp_en_i ? '0 : (pop ? nxt(rd_q) : rd_q);
            wr_q    <= jmp_en_i ? '0 : (push ? nxt(wr_q) : wr_q);
            cnt_q   <= jmp_en_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_e;
    end
    assign head          = mem_q[rd_q];
    assign instr_valid_o = cnt_q != '0;
    assign instr_op_o    = instr_valid_o ? head.op : '0;
    assign instr_arg_o   = instr_valid_o ? head.arg : '0;
    assign instr_pc_o    = instr_valid_o ? head.pc : '0;
    assign rom_addr_o    = pc_q;
    assign rom_read_o    = rd;
    assign rom_ena_o     = rd;
    assign halted_o      = state_q == HALTED;
    assign busy_o        = state_q == FETCH_OP || state_q == FETCH_ARG;
endmodule

// File: tb/tb_rom_fetch_unit.sv
// tb_rom_fetch_unit: table-driven and directed checks with an ISA-level scoreboard of emitted instructions
module tb_rom_fetch_unit;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0, jmp_en = 0, ready = 0;
    logic [7:0] jmp_addr = 0;
    logic [7:0] rom_addr, rom_data, op, arg, pc;
    logic       rom_read, rom_ena, valid, halted, busy;
    logic [7:0] rom [256];
    int         n_chk = 0, n_fail = 0;
    typedef struct {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
    } exp_t;
    exp_t exp_q[$];
    typedef struct {
        logic [7:0] addr;
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] exp_arg;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    rom_fetch_unit dut (
        .clk(clk), .rst(rst), .start_i(start), .jmp_en_i(jmp_en), .jmp_addr_i(jmp_addr),
        .rom_addr_o(rom_addr), .rom_read_o(rom_read), .rom_ena_o(rom_ena), .rom_data_i(rom_data),
        .instr_valid_o(valid), .instr_ready_i(ready), .instr_op_o(op), .instr_arg_o(arg),
        .instr_pc_o(pc), .halted_o(halted), .busy_o(busy)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic bit is_two(logic [7:0] o);
        return o[7:5] == 3'd1 || o[7:5] == 3'd2 || o[7:5] == 3'd3;
    endfunction

    // walks the program in ROM from address a until HLT and queues each instruction
    task automatic expect_prog(input logic [7:0] a);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            logic [7:0] a1;
            a1    = a + 8'd1;
            e.op  = rom[a];
            e.arg = is_two(e.op) ? rom[a1] : 8'h00;
            e.pc  = a;
            exp_q.push_back(e);
            a = is_two(e.op) ? a + 8'd2 : a1;
            if (e.op[7:5] == 3'b111) break;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid && ready && !jmp_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got op=%0h arg=%0h pc=%0h expected nothing", op, arg, pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_op", op, e.op);
                check("sb_arg", arg, e.arg);
                check("sb_pc", pc, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
        rst = 1;
        start = 0;
        jmp_en = 0;
        ready = 0;
        tick();
        tick();
        rst = 0;
        exp_q.delete();
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 30 && !halted; i++) tick();
        check("halt_reached", halted, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && valid; i++) tick();
        check("drained", valid, 0);
    endtask

    task automatic jump(input logic [7:0] a);
        jmp_en = 1;
        jmp_addr = a;
        tick();
        jmp_en = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h10, 8'h20, 8'h5A, 8'h5A};
        vecs[1] = '{8'h20, 8'h40, 8'hA5, 8'hA5};
        vecs[2] = '{8'h30, 8'h7F, 8'h3C, 8'h3C};
        vecs[3] = '{8'h40, 8'h00, 8'h99, 8'h00};
        vecs[4] = '{8'h50, 8'h9F, 8'h11, 8'h00};
        vecs[5] = '{8'h60, 8'hBF, 8'h22, 8'h00};
        vecs[6] = '{8'h70, 8'hC3, 8'h33, 8'h00};
        vecs[7] = '{8'h80, 8'hE5, 8'h77, 8'h00};
        vecs[8] = '{8'hFF, 8'h61, 8'h01, 8'h01};

        do_reset();
        check("rst_valid", valid, 0);
        check("rst_read", rom_read, 0);
        check("rst_ena", rom_ena, 0);
        check("rst_halted", halted, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_head", {op, arg, pc}, 0);

        // basic latency: 1-byte then 2-byte instruction
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'h41; rom[3] = 8'hE0;
        ready = 1;
        expect_prog(8'h00);
        start = 1;
        tick();
        start = 0;
        check("t1_c1_read", rom_read, 1);
        check("t1_c1_addr", rom_addr, 8'h00);
        tick();
        check("t1_c2_valid", valid, 1);
        check("t1_c2_head", {op, pc}, 16'h0000);
        tick();
        check("t1_c3_valid", valid, 0);
        tick();
        check("t1_c4_valid", valid, 1);
        check("t1_c4_head", {op, arg, pc}, 24'h214101);
        tick();
        check("t1_c5_halted", halted, 1);
        check("t1_c5_ena", rom_ena, 0);
        wait_drain();

        // decode table: one instruction followed by HLT, entered via jump
        for (int v = 0; v < 9; v++) begin
            logic [7:0] a1, ah;
            bit hlt;
            do_reset();
            hlt = vecs[v].op[7:5] == 3'b111;
            a1 = vecs[v].addr + 8'd1;
            ah = vecs[v].addr + (is_two(vecs[v].op) ? 8'd2 : 8'd1);
            rom[vecs[v].addr] = vecs[v].op;
            rom[a1] = vecs[v].arg;
            if (!hlt) rom[ah] = 8'hE0;
            jump(vecs[v].addr);
            wait_halt();
            check("vec_op", op, vecs[v].op);
            check("vec_arg", arg, vecs[v].exp_arg);
            check("vec_pc", pc, vecs[v].addr);
            check("vec_halt_pc", rom_addr, hlt ? ah : ah + 8'd1);
            check("vec_halt_ena", rom_ena, 0);
            expect_prog(vecs[v].addr);
            ready = 1;
            wait_drain();
            ready = 0;
        end

        // backpressure: FIFO fills, fetch stops, head holds, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) rom[i] = 8'(i + 1);
        rom[5] = 8'hE0;
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        check("t2_full_ena", rom_ena, 0);
        check("t2_full_read", rom_read, 0);
        check("t2_pc_hold", rom_addr, 8'h02);
        check("t2_head", {op, pc}, 16'h0100);
        tick();
        check("t2_head_stable", {op, pc}, 16'h0100);
        expect_prog(8'h00);
        ready = 1;
        check("t2_pop_no_fetch", rom_read, 0);
        tick();
        check("t2_refetch", rom_read, 1);
        wait_halt();
        wait_drain();

        // HLT and resume
        do_reset();
        rom[8'h13] = 8'hE0;
        rom[8'h14] = 8'hE0;
        ready = 1;
        expect_prog(8'h13);
        jump(8'h13);
        check("t3_read_addr", rom_addr, 8'h13);
        tick();
        check("t3_halted", halted, 1);
        check("t3_ena", rom_ena, 0);
        check("t3_halt_pc", rom_addr, 8'h14);
        expect_prog(8'h14);
        start = 1;
        tick();
        start = 0;
        check("t3_resume_addr", rom_addr, 8'h14);
        check("t3_resume_busy", busy, 1);
        wait_halt();
        wait_drain();

        // jump during FETCH_ARG discards the fragment
        do_reset();
        rom[8'h0A] = 8'h20;
        rom[8'h0B] = 8'h33;
        ready = 1;
        expect_prog(8'h41);
        jump(8'h0A);
        tick();
        check("t4_arg_addr", rom_addr, 8'h0B);
        check("t4_busy", busy, 1);
        jump(8'h41);
        check("t4_valid", valid, 0);
        check("t4_target", rom_addr, 8'h41);
        check("t4_read", rom_read, 1);
        wait_halt();
        wait_drain();

        // reset mid-instruction with queued data
        do_reset();
        rom[0] = 8'h00; rom[1] = 8'h21; rom[2] = 8'h41;
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        check("t6_pre_valid", valid, 1);
        check("t6_pre_busy", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        check("t6_valid", valid, 0);
        check("t6_ena", rom_ena, 0);
        check("t6_addr", rom_addr, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_head", {op, arg, pc}, 0);
        tick();
        check("t6_idle", busy, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
